// File: rtl/issue_ctrl.sv
// In-order issue controller: tracks in-flight destination registers in a small FIFO,
// stalls on RAW hazards or a full FIFO, and trims younger entries on a flush.
module issue_ctrl #(
  parameter int REG_CNT        = 32,
  parameter int REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic                      issue_uses_rs1,
  input  logic                      issue_uses_rs2,
  input  logic                      issue_writes_rd,
  input  logic                      exec_idle,
  output logic                      issue_ready,
  input  logic                      retire_valid,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    inflight_cnt,
  output logic [REG_ADDR_WIDTH-1:0] head_rd,
  output logic [REG_CNT-1:0]        busy_mask,
  output logic                      stall_raw,
  output logic                      stall_full,
  output logic                      err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_WIDTH-1:0] entry_rd_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] entry_rd_d [DEPTH];
  logic [DEPTH-1:0]          entry_wr_q, entry_wr_d;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      err_q, err_d;

  logic [DEPTH-1:0]   entry_valid;
  logic [REG_CNT-1:0] busy_raw;
  logic               raw, full, nonempty, fire, pop;

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    entry_valid = '0;
    busy_raw    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
      if (entry_valid[i] && entry_wr_q[i])
        busy_raw[entry_rd_q[i]] = 1'b1;
    end
  end

  always_comb begin
    nonempty    = count_q != '0;
    full        = count_q == CNT_W'(DEPTH);
    raw         = (issue_uses_rs1 & busy_raw[issue_rs1]) |
                  (issue_uses_rs2 & busy_raw[issue_rs2]);
    issue_ready = !rst & exec_idle & !flush & !raw & !full;
    fire        = issue_valid & issue_ready;
    pop         = retire_valid & nonempty;

    stall_raw     = !rst & issue_valid & raw;
    stall_full    = !rst & issue_valid & full;
    busy_mask     = rst ? '0 : busy_raw;
    inflight_cnt  = rst ? '0 : count_q;
    head_rd       = (!rst && nonempty) ? entry_rd_q[head_q] : '0;
    err_underflow = err_q;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    err_d      = err_q;
    entry_rd_d = entry_rd_q;
    entry_wr_d = entry_wr_q;

    if (fire) begin
      entry_rd_d[tail_q] = issue_rd;
      entry_wr_d[tail_q] = issue_writes_rd & (issue_rd != '0);
    end

    if (retire_valid && !nonempty)
      err_d = 1'b1;

    // Flushing head survives unless it also retires this cycle; fire is blocked here.
    if (flush && nonempty) begin
      tail_d = head_q + PTR_W'(1);
      if (retire_valid) begin
        head_d  = head_q + PTR_W'(1);
        count_d = '0;
      end else begin
        count_d = CNT_W'(1);
      end
    end else begin
      if (fire) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      entry_wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_rd_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      entry_wr_q <= entry_wr_d;
      for (int i = 0; i < DEPTH; i++) entry_rd_q[i] <= entry_rd_d[i];
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl: hazards, x0/WAW, full/wrap, flush,
// underflow and mid-operation reset.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
  logic        exec_idle;
  logic        issue_ready;
  logic        retire_valid;
  logic        flush;
  logic [2:0]  inflight_cnt;
  logic [4:0]  head_rd;
  logic [31:0] busy_mask;
  logic        stall_raw, stall_full, err_underflow;

  int total = 0;
  int bad   = 0;

  issue_ctrl #(.REG_CNT(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_writes_rd(issue_writes_rd), .exec_idle(exec_idle),
    .issue_ready(issue_ready), .retire_valid(retire_valid), .flush(flush),
    .inflight_cnt(inflight_cnt), .head_rd(head_rd), .busy_mask(busy_mask),
    .stall_raw(stall_raw), .stall_full(stall_full), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks run 1ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic wr,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic ret, input logic fl);
    issue_valid     = v;
    issue_rd        = rd;
    issue_writes_rd = wr;
    issue_rs1       = rs1;
    issue_uses_rs1  = u1;
    issue_rs2       = rs2;
    issue_uses_rs2  = u2;
    retire_valid    = ret;
    flush           = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int exp_head [10];

    rst       = 1'b1;
    exec_idle = 1'b1;
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("rst_ready", 32'(issue_ready), 32'd0);
    checkOutput("rst_busy", busy_mask, 32'h0);
    checkOutput("rst_cnt", 32'(inflight_cnt), 32'd0);
    checkOutput("rst_head", 32'(head_rd), 32'd0);
    checkOutput("rst_stall_full", 32'(stall_full), 32'd0);
    tick();

    rst = 1'b0;
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("first_ready", 32'(issue_ready), 32'd1);
    checkOutput("first_cnt", 32'(inflight_cnt), 32'd0);
    tick();

    // x5 in flight; a reader of x5 must stall until the cycle after the retire.
    applyStimulus(1, 5'd6, 1, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("push_cnt", 32'(inflight_cnt), 32'd1);
    checkOutput("push_busy", busy_mask, 32'h20);
    checkOutput("push_head", 32'(head_rd), 32'd5);
    checkOutput("raw_ready", 32'(issue_ready), 32'd0);
    checkOutput("raw_stall", 32'(stall_raw), 32'd1);
    tick();
    applyStimulus(1, 5'd6, 1, 5'd5, 1, 5'd0, 0, 1, 0);
    checkOutput("raw_retire_ready", 32'(issue_ready), 32'd0);
    checkOutput("raw_retire_stall", 32'(stall_raw), 32'd1);
    tick();
    applyStimulus(1, 5'd6, 1, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("raw_clear_cnt", 32'(inflight_cnt), 32'd0);
    checkOutput("raw_clear_busy", busy_mask, 32'h0);
    checkOutput("raw_clear_ready", 32'(issue_ready), 32'd1);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    tick();

    // x0 never becomes busy, and a reader of x0 never stalls.
    applyStimulus(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("x0_ready", 32'(issue_ready), 32'd1);
    tick();
    applyStimulus(1, 5'd7, 1, 5'd0, 1, 5'd0, 1, 0, 0);
    checkOutput("x0_busy", busy_mask, 32'h0);
    checkOutput("x0_cnt", 32'(inflight_cnt), 32'd1);
    checkOutput("x0_read_ready", 32'(issue_ready), 32'd1);
    checkOutput("x0_read_stall", 32'(stall_raw), 32'd0);
    tick();
    applyStimulus(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("waw_ready", 32'(issue_ready), 32'd1);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("waw_cnt2", 32'(inflight_cnt), 32'd2);
    checkOutput("waw_busy2", busy_mask, 32'h80);
    checkOutput("waw_head", 32'(head_rd), 32'd7);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("waw_busy1", busy_mask, 32'h80);
    checkOutput("waw_cnt1", 32'(inflight_cnt), 32'd1);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("waw_busy0", busy_mask, 32'h0);

    // Fill the FIFO with four independent writers.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 5'(k), 1, 5'd0, 0, 5'd0, 0, 0, 0);
      checkOutput("fill_ready", 32'(issue_ready), 32'd1);
      tick();
    end
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("full_cnt", 32'(inflight_cnt), 32'd4);
    checkOutput("full_busy", busy_mask, 32'h1E);
    checkOutput("full_stall", 32'(stall_full), 32'd1);
    checkOutput("full_ready", 32'(issue_ready), 32'd0);
    tick();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("full_retire_ready", 32'(issue_ready), 32'd0);
    checkOutput("full_retire_stall", 32'(stall_full), 32'd1);
    tick();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("after_retire_cnt", 32'(inflight_cnt), 32'd3);
    checkOutput("after_retire_ready", 32'(issue_ready), 32'd1);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("refill_cnt", 32'(inflight_cnt), 32'd4);
    tick();

    // FIFO holds rd 3,4,9; ten push/pop pairs wrap both pointers.
    exp_head[0] = 3;
    exp_head[1] = 4;
    exp_head[2] = 9;
    for (int k = 3; k < 10; k++) exp_head[k] = 7 + k;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 5'(10 + k), 1, 5'd0, 0, 5'd0, 0, 1, 0);
      checkOutput("wrap_head", 32'(head_rd), 32'(exp_head[k]));
      checkOutput("wrap_ready", 32'(issue_ready), 32'd1);
      checkOutput("wrap_cnt", 32'(inflight_cnt), 32'd3);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
      checkOutput("drain_head", 32'(head_rd), 32'(17 + k));
      tick();
    end

    // Flush with rd 1,2,3 in flight keeps only the head.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 5'(k), 1, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 1);
    checkOutput("flush_pre_cnt", 32'(inflight_cnt), 32'd3);
    checkOutput("flush_ready", 32'(issue_ready), 32'd0);
    tick();
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("flush_cnt", 32'(inflight_cnt), 32'd1);
    checkOutput("flush_busy", busy_mask, 32'h2);
    checkOutput("flush_head", 32'(head_rd), 32'd1);
    tick();
    applyStimulus(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
    checkOutput("flush2_pre_cnt", 32'(inflight_cnt), 32'd3);
    checkOutput("flush2_pre_busy", busy_mask, 32'hE);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("flush_retire_cnt", 32'(inflight_cnt), 32'd0);
    checkOutput("flush_retire_busy", busy_mask, 32'h0);
    checkOutput("pre_underflow_err", 32'(err_underflow), 32'd0);

    // Retire on an empty FIFO is sticky-flagged and otherwise ignored.
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("underflow_err", 32'(err_underflow), 32'd1);
    checkOutput("underflow_cnt", 32'(inflight_cnt), 32'd0);
    tick();
    checkOutput("underflow_sticky", 32'(err_underflow), 32'd1);

    // Reset with two entries in flight discards them and clears the flag.
    applyStimulus(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    rst = 1'b1;
    applyStimulus(1, 5'd6, 1, 5'd4, 1, 5'd0, 0, 0, 0);
    checkOutput("midrst_ready", 32'(issue_ready), 32'd0);
    checkOutput("midrst_busy", busy_mask, 32'h0);
    checkOutput("midrst_cnt", 32'(inflight_cnt), 32'd0);
    checkOutput("midrst_stall_raw", 32'(stall_raw), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1, 5'd6, 1, 5'd4, 1, 5'd0, 0, 0, 0);
    checkOutput("postrst_err", 32'(err_underflow), 32'd0);
    checkOutput("postrst_cnt", 32'(inflight_cnt), 32'd0);
    checkOutput("postrst_head", 32'(head_rd), 32'd0);
    checkOutput("postrst_ready", 32'(issue_ready), 32'd1);
    exec_idle = 1'b0;
    #1;
    checkOutput("postrst_not_idle", 32'(issue_ready), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order issue controller between decode and execute.
- Tracks destination registers of instructions already issued but not yet retired, held in a small in-flight FIFO.
- Stalls issue on read-after-write hazards or when the FIFO is full.
- Discards killed younger instructions when execute flushes the pipeline on a taken branch or jump.

Parameters:
REG_CNT, 32, number of architectural registers
REG_ADDR_WIDTH, $clog2(REG_CNT), register address width
DEPTH, 4, max in-flight instructions (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
issue_valid  input  1  decode holds a decoded instruction
issue_rd  input  REG_ADDR_WIDTH  destination register
issue_rs1  input  REG_ADDR_WIDTH  source 1
issue_rs2  input  REG_ADDR_WIDTH  source 2
issue_uses_rs1  input  1  instruction reads rs1
issue_uses_rs2  input  1  instruction reads rs2
issue_writes_rd  input  1  instruction writes rd
exec_idle  input  1  execute can accept an instruction this cycle
issue_ready  output  1  issue permitted; fire = issue_valid & issue_ready
retire_valid  input  1  oldest in-flight instruction completed writeback/discard
flush  input  1  oldest in-flight instruction redirected PC; kill all younger
inflight_cnt  output  $clog2(DEPTH)+1  entries in FIFO
head_rd  output  REG_ADDR_WIDTH  rd of oldest entry (0 when empty)
busy_mask  output  REG_CNT  bit r set iff a valid entry writes r (bit 0 always 0)
stall_raw  output  1  issue_valid & RAW hazard
stall_full  output  1  issue_valid & FIFO full
err_underflow  output  1  sticky: retire_valid seen with FIFO empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset effects:
  - FIFO pointers, count and err_underflow are cleared.
  - While rst is high, issue_ready=0, stall_raw=0, stall_full=0, busy_mask=0, head_rd=0, inflight_cnt=0.
  - Reset mid-operation discards all entries; the cycle after rst falls, issue_ready=exec_idle.
- FIFO entry: {rd, wr}, where wr = issue_writes_rd & (issue_rd != 0).
- busy_mask is the OR over valid entries of onehot(rd) where wr=1. It is combinational from registered state only.
- Hazard: raw = (issue_uses_rs1 & busy_mask[issue_rs1]) | (issue_uses_rs2 & busy_mask[issue_rs2]). x0 never hazards.
- No bypass: an entry retired in cycle N clears its busy bit in cycle N+1. A hazard seen in cycle N still stalls in cycle N.
- issue_ready = !rst & exec_idle & !flush & !raw & (count < DEPTH). A retire in the same cycle does not free a slot for a full FIFO.
- WAW is not a hazard. Multiple entries may hold the same rd; the bit stays busy until the last one retires.
- Fire: push the entry at tail; tail <= tail+1 (mod DEPTH, wraps).
- retire_valid with count>0: pop the head; head <= head+1 (wraps).
- Fire and retire in the same cycle: count is unchanged, both pointers advance.
- retire_valid with count=0: ignored, and err_underflow <= 1. It stays set until reset.
- flush (sampled only when count>0):
  - The head entry is the flushing instruction and survives; all younger entries are dropped: tail <= head+1, count <= 1.
  - flush and retire_valid in the same cycle: head is popped and count <= 0.
  - No fire is possible in a flush cycle (issue_ready=0).
  - flush with count=0: no effect.
- Latency: an issue decision is combinational in the same cycle. The push is visible in busy_mask/inflight_cnt the next cycle.
- head_rd = rd of the head entry if count>0, else 0.

Test Plan:
- Reset, then issue rd=5 with exec_idle=1 -> issue_ready=1 in the fire cycle; next cycle inflight_cnt=1, busy_mask=0x20, head_rd=5.
- RAW, no bypass:
  - With x5 in flight, issue rs1=5 uses_rs1=1 -> issue_ready=0, stall_raw=1.
  - Assert retire_valid in cycle N -> still stalled in N; issue_ready=1 in N+1.
- x0 and WAW:
  - Issue rd=0 writes_rd=1 -> busy_mask stays 0; a following rs1=0 is never stalled.
  - Issue rd=7 twice; retire one -> bit 7 stays set until the second retires.
- Full and wrap:
  - Issue 4 independent instructions -> inflight_cnt=4, stall_full=1.
  - Retire alone -> no issue that cycle, issue_ready=1 the next.
  - Continue for 10 push/pop pairs -> head_rd sequence matches issue order across pointer wrap.
- Flush with 3 entries (rd=1,2,3):
  - flush alone -> inflight_cnt=1, busy_mask=0x2, issue_ready=0 during the flush cycle.
  - flush+retire_valid together -> inflight_cnt=0, busy_mask=0.
- Underflow and reset mid-op:
  - retire_valid at count=0 -> err_underflow=1, count stays 0.
  - Assert rst with 2 entries in flight -> next cycle all outputs 0 and err_underflow=0.
